// File: rtl/rf_pkg.sv
// rf_pkg: clear-sequencer state type and default sizes
// shared by param_register_file and rf_clear_sequencer.
package rf_pkg;

    typedef enum logic {
        RF_SWEEP = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 4;
    localparam int RF_ADDR_W = 2;

endpackage

// File: rtl/rf_clear_sequencer.sv
// rf_clear_sequencer: SWEEP/READY state machine that zeroes every
// register entry after reset or on clear_req, one entry per edge.
module rf_clear_sequencer
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        unique case (state_q)
            RF_SWEEP: begin
                // an edge with rst high only restarts the sweep
                clr_we = ~rst;
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d = RF_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RF_READY: begin
                if (clear_req) begin
                    state_d = RF_SWEEP;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = RF_SWEEP;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_SWEEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q == RF_SWEEP);
    assign clr_addr = idx_q;

endmodule

// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with clear sweep.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module param_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W      = RF_DATA_W,
    parameter int ADDR_W      = RF_ADDR_W,
    parameter int NUM_RD      = 2,
    parameter int HARDWIRE_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;

    rf_clear_sequencer #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .clear_req(clear_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // clear wins over a simultaneous write; r0 writes vanish when hardwired
    always_comb begin
        wr_en = reg_write & ~busy & ~clear_req & ~rst;
        if ((HARDWIRE_R0 != 0) && (write_reg == '0)) begin
            wr_en = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = read_reg[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (addr == write_reg)) begin
                val = write_data;
            end
`endif
            if ((HARDWIRE_R0 != 0) && (addr == '0)) begin
                val = '0;
            end
            if (busy) begin
                val = '0;
            end
        end

        assign read_data[k*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: scoreboard bench for a default instance and
// an 8-bit/8-entry/3-port instance with hardwired r0.
module tb_param_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, we_a, clr_a, busy_a;
    logic [1:0]  wr_a;
    logic [3:0]  wd_a;
    logic [3:0]  rr_a;
    logic [7:0]  rd_a;

    logic        rst_b, we_b, clr_b, busy_b;
    logic [2:0]  wr_b;
    logic [7:0]  wd_b;
    logic [8:0]  rr_b;
    logic [23:0] rd_b;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    param_register_file u_a (
        .clk       (clk),
        .rst       (rst_a),
        .reg_write (we_a),
        .write_reg (wr_a),
        .write_data(wd_a),
        .read_reg  (rr_a),
        .read_data (rd_a),
        .clear_req (clr_a),
        .busy      (busy_a)
    );

    param_register_file #(
        .DATA_W     (8),
        .ADDR_W     (3),
        .NUM_RD     (3),
        .HARDWIRE_R0(1)
    ) u_b (
        .clk       (clk),
        .rst       (rst_b),
        .reg_write (we_b),
        .write_reg (wr_b),
        .write_data(wd_b),
        .read_reg  (rr_b),
        .read_data (rd_b),
        .clear_req (clr_b),
        .busy      (busy_b)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_v(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] v);
        obs_q.push_back(v);
    endtask

    function automatic logic [31:0] pa(input int k);
        return 32'(rd_a[k*4 +: 4]);
    endfunction

    function automatic logic [31:0] pb(input int k);
        return 32'(rd_b[k*8 +: 8]);
    endfunction

    task automatic test_reset();
        exp_t        e;
        logic [31:0] o;
        rst_a = 1'b1;
        cyc();
        expect_v("rst_busy", 32'd1);
        expect_v("rst_p0", 32'd0);
        expect_v("rst_p1", 32'd0);
        #1;
        observe(32'(busy_a));
        observe(pa(0));
        observe(pa(1));
        rst_a = 1'b0;
        rr_a  = {2'd3, 2'd1};
        for (int i = 1; i <= 4; i++) begin
            cyc();
            we_a = (i == 1);
            wr_a = 2'd0;
            wd_a = 4'h9;
            expect_v($sformatf("sweep_busy_e%0d", i), (i < 4) ? 32'd1 : 32'd0);
            #1;
            observe(32'(busy_a));
        end
        we_a = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rr_a = {r[1:0], r[1:0]};
            expect_v($sformatf("swept_r%0d_p0", r), 32'd0);
            expect_v($sformatf("swept_r%0d_p1", r), 32'd0);
            #1;
            observe(pa(0));
            observe(pa(1));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t        e;
        logic [31:0] o;
        cyc();
        we_a = 1'b1;
        wr_a = 2'd2;
        wd_a = 4'hA;
        cyc();
        wr_a = 2'd3;
        wd_a = 4'h5;
        cyc();
        we_a = 1'b0;
        rr_a = {2'd3, 2'd2};
        expect_v("wr_p0_r2", 32'hA);
        expect_v("wr_p1_r3", 32'h5);
        expect_v("wr_busy", 32'd0);
        #1;
        observe(pa(0));
        observe(pa(1));
        observe(32'(busy_a));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t        e;
        logic [31:0] o;
        cyc();
        we_a = 1'b1;
        wr_a = 2'd1;
        wd_a = 4'h7;
        rr_a = {2'd2, 2'd1};
        expect_v("byp_same_cycle_r1", BYP ? 32'h7 : 32'h0);
        expect_v("byp_other_r2", 32'hA);
        #1;
        observe(pa(0));
        observe(pa(1));
        cyc();
        we_a = 1'b0;
        expect_v("byp_next_cycle_r1", 32'h7);
        #1;
        observe(pa(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_clear_collision();
        exp_t        e;
        logic [31:0] o;
        for (int r = 0; r < 4; r++) begin
            cyc();
            we_a = 1'b1;
            wr_a = r[1:0];
            wd_a = 4'hF;
        end
        cyc();
        we_a = 1'b0;
        rr_a = {2'd1, 2'd0};
        expect_v("fill_r0", 32'hF);
        expect_v("fill_r1", 32'hF);
        #1;
        observe(pa(0));
        observe(pa(1));
        rr_a = {2'd3, 2'd2};
        expect_v("fill_r2", 32'hF);
        expect_v("fill_r3", 32'hF);
        #1;
        observe(pa(0));
        observe(pa(1));
        cyc();
        clr_a = 1'b1;
        we_a  = 1'b1;
        wr_a  = 2'd1;
        wd_a  = 4'h3;
        rr_a  = {2'd2, 2'd1};
        expect_v("coll_no_bypass_r1", 32'hF);
        expect_v("coll_busy_pre", 32'd0);
        #1;
        observe(pa(0));
        observe(32'(busy_a));
        for (int i = 0; i <= 4; i++) begin
            cyc();
            clr_a = 1'b0;
            we_a  = 1'b0;
            expect_v($sformatf("coll_busy_e%0d", i), (i < 4) ? 32'd1 : 32'd0);
            expect_v($sformatf("coll_read_e%0d", i), 32'd0);
            #1;
            observe(32'(busy_a));
            observe(pa(0));
        end
        for (int r = 0; r < 4; r += 2) begin
            rr_a = {2'(r + 1), 2'(r)};
            expect_v($sformatf("coll_clr_r%0d", r), 32'd0);
            expect_v($sformatf("coll_clr_r%0d", r + 1), 32'd0);
            #1;
            observe(pa(0));
            observe(pa(1));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t        e;
        logic [31:0] o;
        for (int r = 0; r < 4; r++) begin
            cyc();
            we_a = 1'b1;
            wr_a = r[1:0];
            wd_a = 4'hF;
        end
        cyc();
        we_a  = 1'b0;
        clr_a = 1'b1;
        cyc();
        clr_a = 1'b0;
        cyc();
        cyc();
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        expect_v("midrst_busy_e0", 32'd1);
        #1;
        observe(32'(busy_a));
        for (int i = 1; i <= 4; i++) begin
            cyc();
            expect_v($sformatf("midrst_busy_e%0d", i), (i < 4) ? 32'd1 : 32'd0);
            #1;
            observe(32'(busy_a));
        end
        for (int r = 0; r < 4; r += 2) begin
            rr_a = {2'(r + 1), 2'(r)};
            expect_v($sformatf("midrst_r%0d", r), 32'd0);
            expect_v($sformatf("midrst_r%0d", r + 1), 32'd0);
            #1;
            observe(pa(0));
            observe(pa(1));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_hw_r0();
        exp_t        e;
        logic [31:0] o;
        int          n;
        cyc();
        rst_b = 1'b0;
        expect_v("b_rst_busy", 32'd1);
        #1;
        observe(32'(busy_b));
        n = 0;
        while (busy_b === 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        expect_v("b_sweep_edges", 32'd8);
        observe(32'(n));
        we_b = 1'b1;
        wr_b = 3'd0;
        wd_b = 8'h55;
        rr_b = {3'd0, 3'd7, 3'd0};
        expect_v("b_r0_no_bypass", 32'd0);
        #1;
        observe(pb(0));
        cyc();
        wr_b = 3'd7;
        wd_b = 8'hAA;
        cyc();
        we_b = 1'b0;
        rr_b = {3'd7, 3'd7, 3'd0};
        expect_v("b_r0_reads0", 32'd0);
        expect_v("b_r7_p1", 32'hAA);
        expect_v("b_r7_p2", 32'hAA);
        #1;
        observe(pb(0));
        observe(pb(1));
        observe(pb(2));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        we_a  = 1'b0;
        clr_a = 1'b0;
        wr_a  = '0;
        wd_a  = '0;
        rr_a  = '0;
        rst_b = 1'b1;
        we_b  = 1'b0;
        clr_b = 1'b0;
        wr_b  = '0;
        wd_b  = '0;
        rr_b  = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_collision();
        test_mid_reset();
        test_hw_r0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
